lpif_dstrm_pack_x16_asym2_half: RTL and testbench



---
 rtl/lpif_pack_pkg.sv | 28 ++
 rtl/lpif_dstrm_pack_x16_asym2_half_idle_timer.sv | 37 +++
 rtl/lpif_dstrm_pack_x16_asym2_half.sv | 177 +++++++++++++++++
 tb/tb_lpif_dstrm_pack_x16_asym2_half.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpif_pack_pkg.sv
// Shared definitions for the LPIF downstream beat packer.
// Holds the per-lane field widths, the per-lane packed payload struct and
// the packer FSM state encoding.
package lpif_pack_pkg;

  localparam int DATA_W   = 256;
  localparam int CRC_W    = 16;
  localparam int STATE_W  = 4;
  localparam int PROTID_W = 2;
  localparam int DVALID_W = 1;
  localparam int CRCV_W   = 1;
  localparam int VALID_W  = 1;

  typedef struct packed {
    logic [STATE_W-1:0]  state;
    logic [PROTID_W-1:0] protid;
    logic [DATA_W-1:0]   data;
    logic [DVALID_W-1:0] dvalid;
    logic [CRC_W-1:0]    crc;
    logic [CRCV_W-1:0]   crc_valid;
  } lpif_lane_t;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } pack_state_e;

endpackage

// File: rtl/lpif_dstrm_pack_x16_asym2_half_idle_timer.sv
// lpif_pack_idle_timer: idle-cycle counter for the half-word flush.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_run         packer is holding lane 0 and no beat moved this cycle;
//                 deasserting it clears the count
//   o_expired     the current idle cycle is the TIMEOUT-th one (or later)
// Only instantiated when LPIF_PACK_TIMEOUT_EN is defined.
module lpif_pack_idle_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  output logic o_expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] r_cnt;

  // The count saturates at LIMIT so a flush held off by backpressure stays
  // pending until the output register frees up.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (!i_run) begin
      r_cnt <= '0;
    end else if (r_cnt != LIMIT) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Flags during the idle cycle that completes the count, so the flush
  // lands on the same edge the counter would reach TIMEOUT.
  assign o_expired = i_run && (r_cnt >= (LIMIT - 8'd1));

endmodule

// File: rtl/lpif_dstrm_pack_x16_asym2_half.sv
// lpif_dstrm_pack_x16_asym2_half: downstream beat packer for the x16
// asymmetric-2 half-rate LPIF path. Pairs two single-lane beats into one
// two-lane dstrm word (lane 0 = first beat, lane 1 = second beat), or emits
// a single-lane word when a beat carries in_last while no beat is held.
// Ports:
//   clk_wr, rst_wr                  clock, asynchronous active-high reset
//   in_vld/in_rdy/in_last           beat handshake and word-close marker
//   in_state..in_crc_valid          per-beat LPIF fields
//   out_vld/out_rdy                 registered dstrm word handshake
//   dstrm_*                         two-lane word, lane 1 in upper bits
//   pack_partial_cnt                saturating count of single-lane words
// Optional: LPIF_PACK_TIMEOUT_EN flushes a lone held beat after TIMEOUT
// idle cycles.
module lpif_dstrm_pack_x16_asym2_half #(
  parameter int DATA_W  = 256,
  parameter int CRC_W   = 16,
  parameter int TIMEOUT = 16
) (
  input  logic                clk_wr,
  input  logic                rst_wr,
  input  logic                in_vld,
  output logic                in_rdy,
  input  logic                in_last,
  input  logic [3:0]          in_state,
  input  logic [1:0]          in_protid,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_dvalid,
  input  logic [CRC_W-1:0]    in_crc,
  input  logic                in_crc_valid,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic [7:0]          dstrm_state,
  output logic [3:0]          dstrm_protid,
  output logic [2*DATA_W-1:0] dstrm_data,
  output logic [1:0]          dstrm_dvalid,
  output logic [2*CRC_W-1:0]  dstrm_crc,
  output logic [1:0]          dstrm_crc_valid,
  output logic [1:0]          dstrm_valid,
  output logic [15:0]         pack_partial_cnt
);

  import lpif_pack_pkg::*;

  pack_state_e              r_state, w_state_nxt;
  lpif_lane_t               w_beat, r_hold_p0;
  lpif_lane_t               r_lane0_p1, r_lane1_p1, w_ld_lane0, w_ld_lane1;
  logic [2*VALID_W-1:0]     r_valid_p1, w_ld_valid;
  logic                     r_vld_p1;
  logic [15:0]              r_partial_cnt;
  logic                     w_beat_xfer, w_word_xfer, w_out_free;
  logic                     w_load, w_hold_we, w_timeout;

  assign w_out_free  = !r_vld_p1 || out_rdy;
  assign in_rdy      = w_out_free;
  assign w_beat_xfer = in_vld && w_out_free;
  assign w_word_xfer = r_vld_p1 && out_rdy;

  assign w_beat = '{state:     in_state,
                    protid:    in_protid,
                    data:      in_data,
                    dvalid:    in_dvalid,
                    crc:       in_crc,
                    crc_valid: in_crc_valid};

`ifdef LPIF_PACK_TIMEOUT_EN
  logic w_timer_run;

  // Counting stops on any beat transfer and outside HALF.
  assign w_timer_run = (r_state == HALF) && !w_beat_xfer;

  lpif_pack_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .i_clk     (clk_wr),
    .i_rst     (rst_wr),
    .i_run     (w_timer_run),
    .o_expired (w_timeout)
  );
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^(8'(TIMEOUT));
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_hold_we   = 1'b0;
    w_ld_lane0  = w_beat;
    w_ld_lane1  = '0;
    w_ld_valid  = 2'b01;
    case (r_state)
      EMPTY: begin
        if (w_beat_xfer) begin
          if (in_last) begin
            w_load = 1'b1;
          end else begin
            w_hold_we   = 1'b1;
            w_state_nxt = HALF;
          end
        end
      end
      HALF: begin
        // A real beat always beats a simultaneous timeout flush.
        if (w_beat_xfer) begin
          w_load      = 1'b1;
          w_ld_lane0  = r_hold_p0;
          w_ld_lane1  = w_beat;
          w_ld_valid  = 2'b11;
          w_state_nxt = EMPTY;
        end else if (w_timeout && w_out_free) begin
          w_load      = 1'b1;
          w_ld_lane0  = r_hold_p0;
          w_state_nxt = EMPTY;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stage p0: lane-0 hold register
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      r_hold_p0 <= '0;
    end else if (w_hold_we) begin
      r_hold_p0 <= w_beat;
    end
  end

  // Stage p1: dstrm output register
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      r_vld_p1   <= 1'b0;
      r_lane0_p1 <= '0;
      r_lane1_p1 <= '0;
      r_valid_p1 <= '0;
    end else if (w_load) begin
      r_vld_p1   <= 1'b1;
      r_lane0_p1 <= w_ld_lane0;
      r_lane1_p1 <= w_ld_lane1;
      r_valid_p1 <= w_ld_valid;
    end else if (w_word_xfer) begin
      r_vld_p1   <= 1'b0;
      r_lane0_p1 <= '0;
      r_lane1_p1 <= '0;
      r_valid_p1 <= '0;
    end
  end

  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      r_partial_cnt <= '0;
    end else if (w_load && (w_ld_valid == 2'b01) && (r_partial_cnt != 16'hFFFF)) begin
      r_partial_cnt <= r_partial_cnt + 16'd1;
    end
  end

  assign out_vld          = r_vld_p1;
  assign dstrm_state      = {r_lane1_p1.state,     r_lane0_p1.state};
  assign dstrm_protid     = {r_lane1_p1.protid,    r_lane0_p1.protid};
  assign dstrm_data       = {r_lane1_p1.data,      r_lane0_p1.data};
  assign dstrm_dvalid     = {r_lane1_p1.dvalid,    r_lane0_p1.dvalid};
  assign dstrm_crc        = {r_lane1_p1.crc,       r_lane0_p1.crc};
  assign dstrm_crc_valid  = {r_lane1_p1.crc_valid, r_lane0_p1.crc_valid};
  assign dstrm_valid      = r_valid_p1;
  assign pack_partial_cnt = r_partial_cnt;

endmodule

// File: tb/tb_lpif_dstrm_pack_x16_asym2_half.sv
module tb_lpif_dstrm_pack_x16_asym2_half;

  logic         clk_wr = 1'b0;
  logic         rst_wr;
  logic         in_vld;
  logic         in_rdy;
  logic         in_last;
  logic [3:0]   in_state;
  logic [1:0]   in_protid;
  logic [255:0] in_data;
  logic         in_dvalid;
  logic [15:0]  in_crc;
  logic         in_crc_valid;
  logic         out_vld;
  logic         out_rdy;
  logic [7:0]   dstrm_state;
  logic [3:0]   dstrm_protid;
  logic [511:0] dstrm_data;
  logic [1:0]   dstrm_dvalid;
  logic [31:0]  dstrm_crc;
  logic [1:0]   dstrm_crc_valid;
  logic [1:0]   dstrm_valid;
  logic [15:0]  pack_partial_cnt;

  int n_run  = 0;
  int n_fail = 0;
  logic [7:0] tag;

  lpif_dstrm_pack_x16_asym2_half #(
    .DATA_W  (256),
    .CRC_W   (16),
    .TIMEOUT (16)
  ) dut (
    .clk_wr           (clk_wr),
    .rst_wr           (rst_wr),
    .in_vld           (in_vld),
    .in_rdy           (in_rdy),
    .in_last          (in_last),
    .in_state         (in_state),
    .in_protid        (in_protid),
    .in_data          (in_data),
    .in_dvalid        (in_dvalid),
    .in_crc           (in_crc),
    .in_crc_valid     (in_crc_valid),
    .out_vld          (out_vld),
    .out_rdy          (out_rdy),
    .dstrm_state      (dstrm_state),
    .dstrm_protid     (dstrm_protid),
    .dstrm_data       (dstrm_data),
    .dstrm_dvalid     (dstrm_dvalid),
    .dstrm_crc        (dstrm_crc),
    .dstrm_crc_valid  (dstrm_crc_valid),
    .dstrm_valid      (dstrm_valid),
    .pack_partial_cnt (pack_partial_cnt)
  );

  always #5 clk_wr = ~clk_wr;

  function automatic logic [255:0] dat(input logic [7:0] t);
    return {32{t}};
  endfunction

  task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_wr);
    #1;
  endtask

  task automatic beat(input logic last, input logic [3:0] st, input logic [1:0] pid,
                      input logic [7:0] t, input logic dv, input logic cv);
    in_vld       = 1'b1;
    in_last      = last;
    in_state     = st;
    in_protid    = pid;
    in_data      = dat(t);
    in_dvalid    = dv;
    in_crc       = {2{t}};
    in_crc_valid = cv;
  endtask

  task automatic idle;
    in_vld       = 1'b0;
    in_last      = 1'b0;
    in_state     = '0;
    in_protid    = '0;
    in_data      = '0;
    in_dvalid    = 1'b0;
    in_crc       = '0;
    in_crc_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_wr  = 1'b1;
    out_rdy = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_out_vld", out_vld, 1'b0);
    chk("rst_dstrm_valid", dstrm_valid, 2'b00);
    chk("rst_dstrm_data", dstrm_data, '0);
    chk("rst_partial_cnt", pack_partial_cnt, 16'd0);
    rst_wr = 1'b0;
    #1;
    chk("post_rst_in_rdy", in_rdy, 1'b1);

    // Two beats back-to-back form one full word
    out_rdy = 1'b1;
    beat(1'b0, 4'h1, 2'h1, 8'hA1, 1'b1, 1'b1);
    #1;
    chk("full_in_rdy", in_rdy, 1'b1);
    tick();
    chk("full_half_no_vld", out_vld, 1'b0);
    beat(1'b0, 4'h2, 2'h2, 8'hB2, 1'b1, 1'b0);
    tick();
    chk("full_out_vld", out_vld, 1'b1);
    chk("full_data", dstrm_data, {dat(8'hB2), dat(8'hA1)});
    chk("full_valid", dstrm_valid, 2'b11);
    chk("full_state", dstrm_state, 8'h21);
    chk("full_protid", dstrm_protid, 4'h9);
    chk("full_crc", dstrm_crc, 32'hB2B2A1A1);
    chk("full_dvalid", dstrm_dvalid, 2'b11);
    chk("full_crc_valid", dstrm_crc_valid, 2'b01);
    idle();
    tick();
    chk("full_drain_vld", out_vld, 1'b0);
    chk("full_drain_data", dstrm_data, '0);

    // Single beat closed by in_last
    beat(1'b1, 4'h3, 2'h3, 8'hC3, 1'b1, 1'b1);
    tick();
    chk("part_out_vld", out_vld, 1'b1);
    chk("part_valid", dstrm_valid, 2'b01);
    chk("part_state", dstrm_state, 8'h03);
    chk("part_protid", dstrm_protid, 4'h3);
    chk("part_data", dstrm_data, {256'd0, dat(8'hC3)});
    chk("part_crc", dstrm_crc, 32'h0000C3C3);
    chk("part_cnt", pack_partial_cnt, 16'd1);
    idle();
    tick();
    chk("part_drain_vld", out_vld, 1'b0);
    chk("part_drain_valid", dstrm_valid, 2'b00);

    // Backpressure: output held for 5 cycles, then swap with no bubble
    out_rdy = 1'b0;
    beat(1'b0, 4'h4, 2'h0, 8'hD4, 1'b1, 1'b1);
    tick();
    beat(1'b0, 4'h5, 2'h1, 8'hE5, 1'b1, 1'b1);
    tick();
    chk("bp_out_vld", out_vld, 1'b1);
    beat(1'b1, 4'h6, 2'h2, 8'hF6, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_rdy_low", in_rdy, 1'b0);
      chk("bp_data_stable", dstrm_data, {dat(8'hE5), dat(8'hD4)});
      chk("bp_state_stable", dstrm_state, 8'h54);
      tick();
    end
    out_rdy = 1'b1;
    #1;
    chk("bp_release_in_rdy", in_rdy, 1'b1);
    tick();
    chk("bp_swap_vld", out_vld, 1'b1);
    chk("bp_swap_valid", dstrm_valid, 2'b01);
    chk("bp_swap_data", dstrm_data, {256'd0, dat(8'hF6)});
    chk("bp_swap_state", dstrm_state, 8'h06);
    chk("bp_swap_cnt", pack_partial_cnt, 16'd2);
    idle();
    tick();
    chk("bp_drain_vld", out_vld, 1'b0);

    // Continuous stream of 8 beats
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tag = 8'h10 + 8'(i);
      beat(1'b0, 4'(i), 2'(i), tag, 1'b1, 1'b1);
      #1;
      chk("strm_in_rdy", in_rdy, 1'b1);
      tick();
      if (i % 2 == 1) begin
        chk("strm_vld", out_vld, 1'b1);
        chk("strm_data", dstrm_data, {dat(tag), dat(tag - 8'd1)});
        chk("strm_valid", dstrm_valid, 2'b11);
      end else begin
        chk("strm_gap_vld", out_vld, 1'b0);
      end
    end
    idle();
    tick();
    chk("strm_drain_vld", out_vld, 1'b0);

    // Reset while holding lane 0
    beat(1'b0, 4'h7, 2'h3, 8'h5A, 1'b1, 1'b1);
    tick();
    idle();
    #1;
    rst_wr = 1'b1;
    #1;
    chk("midrst_cnt", pack_partial_cnt, 16'd0);
    chk("midrst_out_vld", out_vld, 1'b0);
    chk("midrst_data", dstrm_data, '0);
    rst_wr = 1'b0;
    beat(1'b0, 4'h8, 2'h0, 8'h77, 1'b1, 1'b1);
    tick();
    chk("midrst_fresh_half", out_vld, 1'b0);
    beat(1'b0, 4'h9, 2'h1, 8'h88, 1'b1, 1'b1);
    tick();
    chk("midrst_word_vld", out_vld, 1'b1);
    chk("midrst_word_data", dstrm_data, {dat(8'h88), dat(8'h77)});
    chk("midrst_word_valid", dstrm_valid, 2'b11);
    idle();
    tick();
    chk("midrst_drain_vld", out_vld, 1'b0);

`ifdef LPIF_PACK_TIMEOUT_EN
    // Lone beat flushed after 16 idle cycles
    beat(1'b0, 4'hC, 2'h0, 8'h3C, 1'b1, 1'b1);
    tick();
    idle();
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("to_wait_vld", out_vld, 1'b0);
    end
    tick();
    chk("to_flush_vld", out_vld, 1'b1);
    chk("to_flush_valid", dstrm_valid, 2'b01);
    chk("to_flush_data", dstrm_data, {256'd0, dat(8'h3C)});
    chk("to_flush_cnt", pack_partial_cnt, 16'd1);
    tick();
    chk("to_drain_vld", out_vld, 1'b0);

    // Beat arriving on the 16th idle cycle wins over the flush
    beat(1'b0, 4'hD, 2'h1, 8'h4D, 1'b1, 1'b1);
    tick();
    idle();
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("to_race_wait_vld", out_vld, 1'b0);
    end
    beat(1'b0, 4'hE, 2'h2, 8'h5E, 1'b1, 1'b1);
    tick();
    chk("to_race_vld", out_vld, 1'b1);
    chk("to_race_valid", dstrm_valid, 2'b11);
    chk("to_race_data", dstrm_data, {dat(8'h5E), dat(8'h4D)});
    chk("to_race_cnt", pack_partial_cnt, 16'd1);
    idle();
    repeat (20) tick();
    chk("to_quiet_vld", out_vld, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
